id_ex_stage_hazard: RTL and testbench
=====================================

Name: id_ex_stage_hazard

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline.
- Sits directly upstream of the forwarding unit.
- Registers decoded operands, immediates, register specifiers and control for EXE, and produces the Rs_EXE/Rt_EXE/MemRead_EXE context used for forwarding and hazard checks.
- Generates the front-end stall controls PCWrite/IFIDWrite and inserts bubbles on load-use, branch flush and external stall.

Parameters:
- DATA_W, 32, operand/immediate/PC width.
- CTRL_W, 6, width of the remaining EX/MEM/WB control bundle (ALUOp, ALUSrc, RegDst, MemToReg), passed through opaquely.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- Stall_EXT  input  1  downstream (memory) stall; hold ID/EX.
- Flush_EX  input  1  taken branch/jump resolved in EX; squash ID instruction.
- Valid_ID  input  1  ID holds a real instruction.
- RegWrite_ID, MemRead_ID, MemWrite_ID  input  1 each  decoded controls.
- Ctrl_ID  input  CTRL_W  other decoded controls.
- UsesRt_ID  input  1  ID instruction reads Rt as a source.
- ReadData1_ID, ReadData2_ID, Imm_ID, PC4_ID  input  DATA_W  register-file reads, sign-extended immediate, PC+4.
- Rs_ID, Rt_ID, Rd_ID  input  5  register specifiers.
- Valid_EXE, RegWrite_EXE, MemRead_EXE, MemWrite_EXE  output  1 each  registered.
- Ctrl_EXE  output  CTRL_W  registered.
- ReadData1_EXE, ReadData2_EXE, Imm_EXE, PC4_EXE  output  DATA_W  registered.
- Rs_EXE, Rt_EXE, Rd_EXE  output  5  registered.
- PCWrite, IFIDWrite  output  1  combinational front-end enables.
- Bubble  output  1  combinational: bubble loaded this cycle because of load-use.
- BubbleCount  output  32  load-use bubble counter (optional feature).

Behaviour:
- Reset: all registered outputs are 0; Valid_EXE=0, so the stage holds a bubble.
- Latency: one cycle, ID to EXE.
- Hazard term (combinational): LU = Valid_EXE & MemRead_EXE & Valid_ID & (Rt_EXE!=0) & ((Rt_EXE==Rs_ID) | (UsesRt_ID & Rt_EXE==Rt_ID)).
- Per-edge priority (highest first):
  1. rst: clear all registers.
  2. Flush_EX: load a bubble. LU is ignored. PCWrite=1, IFIDWrite=1.
  3. Stall_EXT: hold all registers. PCWrite=0, IFIDWrite=0.
  4. LU: load a bubble. PCWrite=0, IFIDWrite=0, Bubble=1.
  5. Otherwise: load all ID inputs. PCWrite=1, IFIDWrite=1.
- Bubble contents: Valid, RegWrite, MemRead, MemWrite and Ctrl are cleared. Data and specifier fields are also zeroed, so Rs/Rt/Rd_EXE=0 and forwarding never matches a bubble.
- Valid_ID=0 is loaded as a bubble (all controls forced 0) and never raises LU.
- Bubble is 1 only in case 4. It is 0 under rst, Flush_EX and Stall_EXT.
- Load-use stalls for exactly one cycle. The next cycle EXE holds a bubble, so LU=0 and the dependent instruction advances; the forwarding unit then supplies the load data via the WB path.
- While stalled, LU re-evaluates every cycle against the held EXE contents.
- Stall_EXT asserted across many cycles: contents stay stable and no counter increments.
- rst asserted mid-stall: the next cycle is a clean bubble with PCWrite=1 once rst is deasserted.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: BubbleCount increments by 1 on each cycle with Bubble=1. It saturates at 32'hFFFFFFFF, is cleared by rst and is unaffected by Flush_EX and Stall_EXT.
- Undefined: no counter is built and BubbleCount is tied to 0.

Test Plan:
- Reset: rst=1 for 2 cycles -> all EXE outputs 0, PCWrite=1, IFIDWrite=1, BubbleCount=0.
- Pass-through: load instruction (Rs=2, Rt=8, MemRead=1) -> next cycle ReadData/Imm/PC4 match inputs. Then ID holds an add with Rs=8 -> PCWrite=0, IFIDWrite=0, Bubble=1 for one cycle; Valid_EXE=0, Rt_EXE=0 the following cycle; the add enters EXE one cycle later; BubbleCount=1.
- Rt match: load writes Rt=5; ID has Rt_ID=5. With UsesRt_ID=1 -> stall. With UsesRt_ID=0 -> no stall. Load with Rt=0 followed by an ID reading $0 -> no stall.
- Flush vs hazard: LU condition plus Flush_EX=1 together -> bubble loaded, PCWrite=1, Bubble=0, counter unchanged.
- External stall: Stall_EXT=1 for 3 cycles with changing ID inputs -> EXE outputs frozen, PCWrite=0. On release, the next ID instruction is loaded.
- Saturation (macro on): force the counter near max, then 2 bubbles -> BubbleCount holds at 32'hFFFFFFFF.

Source files
------------

// File: rtl/id_ex_stage_hazard.sv
// rtl/id_ex_stage_hazard.sv - ID/EX pipeline register with load-use hazard detection
// Optional load-use bubble counter enabled by defining HAZ_PERF_CNT_EN.
module id_ex_stage_hazard #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall_EXT,
  input  logic              Flush_EX,
  input  logic              Valid_ID,
  input  logic              RegWrite_ID,
  input  logic              MemRead_ID,
  input  logic              MemWrite_ID,
  input  logic [CTRL_W-1:0] Ctrl_ID,
  input  logic              UsesRt_ID,
  input  logic [DATA_W-1:0] ReadData1_ID,
  input  logic [DATA_W-1:0] ReadData2_ID,
  input  logic [DATA_W-1:0] Imm_ID,
  input  logic [DATA_W-1:0] PC4_ID,
  input  logic [4:0]        Rs_ID,
  input  logic [4:0]        Rt_ID,
  input  logic [4:0]        Rd_ID,
  output logic              Valid_EXE,
  output logic              RegWrite_EXE,
  output logic              MemRead_EXE,
  output logic              MemWrite_EXE,
  output logic [CTRL_W-1:0] Ctrl_EXE,
  output logic [DATA_W-1:0] ReadData1_EXE,
  output logic [DATA_W-1:0] ReadData2_EXE,
  output logic [DATA_W-1:0] Imm_EXE,
  output logic [DATA_W-1:0] PC4_EXE,
  output logic [4:0]        Rs_EXE,
  output logic [4:0]        Rt_EXE,
  output logic [4:0]        Rd_EXE,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              Bubble,
  output logic [31:0]       BubbleCount
);

  logic lu;
  logic upd;
  logic take;

  // A load in EXE whose destination is a source of the ID instruction.
  assign lu = Valid_EXE & MemRead_EXE & Valid_ID & (Rt_EXE != 5'd0) &
              ((Rt_EXE == Rs_ID) | (UsesRt_ID & (Rt_EXE == Rt_ID)));

  assign upd       = Flush_EX | ~Stall_EXT;
  assign take      = ~Flush_EX & ~lu & Valid_ID;
  assign Bubble    = ~rst & ~Flush_EX & ~Stall_EXT & lu;
  assign PCWrite   = rst | Flush_EX | (~Stall_EXT & ~lu);
  assign IFIDWrite = PCWrite;

  // Bubbles zero every field so the forwarding unit can never match one.
  always_ff @(posedge clk) begin
    if (rst) begin
      Valid_EXE     <= 1'b0;
      RegWrite_EXE  <= 1'b0;
      MemRead_EXE   <= 1'b0;
      MemWrite_EXE  <= 1'b0;
      Ctrl_EXE      <= '0;
      ReadData1_EXE <= '0;
      ReadData2_EXE <= '0;
      Imm_EXE       <= '0;
      PC4_EXE       <= '0;
      Rs_EXE        <= '0;
      Rt_EXE        <= '0;
      Rd_EXE        <= '0;
    end else if (upd) begin
      Valid_EXE     <= take;
      RegWrite_EXE  <= take & RegWrite_ID;
      MemRead_EXE   <= take & MemRead_ID;
      MemWrite_EXE  <= take & MemWrite_ID;
      Ctrl_EXE      <= take ? Ctrl_ID      : '0;
      ReadData1_EXE <= take ? ReadData1_ID : '0;
      ReadData2_EXE <= take ? ReadData2_ID : '0;
      Imm_EXE       <= take ? Imm_ID       : '0;
      PC4_EXE       <= take ? PC4_ID       : '0;
      Rs_EXE        <= take ? Rs_ID        : '0;
      Rt_EXE        <= take ? Rt_ID        : '0;
      Rd_EXE        <= take ? Rd_ID        : '0;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      bubble_cnt <= '0;
    else if (Bubble && (bubble_cnt != 32'hFFFF_FFFF))
      bubble_cnt <= bubble_cnt + 32'd1;
  end

  assign BubbleCount = bubble_cnt;
`else
  assign BubbleCount = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_hazard.sv
// tb/tb_id_ex_stage_hazard.sv - table-driven bench for id_ex_stage_hazard
module tb_id_ex_stage_hazard;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 6;
  localparam logic [1:0] A_BUB = 2'd0, A_LOAD = 2'd1, A_HOLD = 2'd2, A_RST = 2'd3;

  typedef struct {
    logic        rst, flush, stall, valid, regw, memr, memw, uses_rt;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d;
    logic        e_pcw, e_bub;
    logic [1:0]  act;
  } vec_t;

  typedef struct {
    logic        valid, regw, memr, memw;
    logic [5:0]  ctrl;
    logic [31:0] rd1, rd2, imm, pc4;
    logic [4:0]  rs, rt, rd;
  } exe_t;

  logic clk = 1'b0;
  logic rst, Stall_EXT, Flush_EX, Valid_ID, RegWrite_ID, MemRead_ID, MemWrite_ID, UsesRt_ID;
  logic [CTRL_W-1:0] Ctrl_ID, Ctrl_EXE;
  logic [DATA_W-1:0] ReadData1_ID, ReadData2_ID, Imm_ID, PC4_ID;
  logic [DATA_W-1:0] ReadData1_EXE, ReadData2_EXE, Imm_EXE, PC4_EXE;
  logic [4:0] Rs_ID, Rt_ID, Rd_ID, Rs_EXE, Rt_EXE, Rd_EXE;
  logic Valid_EXE, RegWrite_EXE, MemRead_EXE, MemWrite_EXE, PCWrite, IFIDWrite, Bubble;
  logic [31:0] BubbleCount;

  int passed = 0;
  int total  = 0;
  exe_t exp_q;
  logic [31:0] exp_cnt;
  vec_t tbl[28];
  vec_t sat[5];

  id_ex_stage_hazard #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .Stall_EXT(Stall_EXT), .Flush_EX(Flush_EX),
    .Valid_ID(Valid_ID), .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID),
    .MemWrite_ID(MemWrite_ID), .Ctrl_ID(Ctrl_ID), .UsesRt_ID(UsesRt_ID),
    .ReadData1_ID(ReadData1_ID), .ReadData2_ID(ReadData2_ID), .Imm_ID(Imm_ID),
    .PC4_ID(PC4_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rd_ID(Rd_ID),
    .Valid_EXE(Valid_EXE), .RegWrite_EXE(RegWrite_EXE), .MemRead_EXE(MemRead_EXE),
    .MemWrite_EXE(MemWrite_EXE), .Ctrl_EXE(Ctrl_EXE), .ReadData1_EXE(ReadData1_EXE),
    .ReadData2_EXE(ReadData2_EXE), .Imm_EXE(Imm_EXE), .PC4_EXE(PC4_EXE),
    .Rs_EXE(Rs_EXE), .Rt_EXE(Rt_EXE), .Rd_EXE(Rd_EXE), .PCWrite(PCWrite),
    .IFIDWrite(IFIDWrite), .Bubble(Bubble), .BubbleCount(BubbleCount)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, f, s, v, rw, mr, mw, ur,
                              input logic [4:0] rs_, rt_, rd_, input logic [31:0] d_,
                              input logic pcw, bub, input logic [1:0] act_);
    vec_t x;
    x.rst = r; x.flush = f; x.stall = s; x.valid = v; x.regw = rw; x.memr = mr;
    x.memw = mw; x.uses_rt = ur; x.rs = rs_; x.rt = rt_; x.rd = rd_; x.d = d_;
    x.e_pcw = pcw; x.e_bub = bub; x.act = act_;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    exe_t n;
    @(negedge clk);
    rst = v.rst; Flush_EX = v.flush; Stall_EXT = v.stall; Valid_ID = v.valid;
    RegWrite_ID = v.regw; MemRead_ID = v.memr; MemWrite_ID = v.memw; UsesRt_ID = v.uses_rt;
    Rs_ID = v.rs; Rt_ID = v.rt; Rd_ID = v.rd;
    ReadData1_ID = v.d; ReadData2_ID = v.d ^ 32'hA5A5_0000;
    Imm_ID = v.d + 32'd1; PC4_ID = v.d + 32'd4; Ctrl_ID = v.d[5:0] ^ 6'h2A;
    #1;
    check({tag, "_pcw"}, {31'd0, PCWrite}, {31'd0, v.e_pcw});
    check({tag, "_ifid"}, {31'd0, IFIDWrite}, {31'd0, v.e_pcw});
    check({tag, "_bubble"}, {31'd0, Bubble}, {31'd0, v.e_bub});
    n = '{default: '0};
    if (v.act == A_HOLD) n = exp_q;
    else if (v.act == A_LOAD) begin
      n.valid = 1'b1; n.regw = v.regw; n.memr = v.memr; n.memw = v.memw;
      n.ctrl = v.d[5:0] ^ 6'h2A; n.rd1 = v.d; n.rd2 = v.d ^ 32'hA5A5_0000;
      n.imm = v.d + 32'd1; n.pc4 = v.d + 32'd4; n.rs = v.rs; n.rt = v.rt; n.rd = v.rd;
    end
    exp_q = n;
`ifdef HAZ_PERF_CNT_EN
    if (v.act == A_RST) exp_cnt = 32'd0;
    else if (v.e_bub && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
`endif
    @(posedge clk);
    #1;
    check({tag, "_valid"}, {31'd0, Valid_EXE}, {31'd0, exp_q.valid});
    check({tag, "_regw"}, {31'd0, RegWrite_EXE}, {31'd0, exp_q.regw});
    check({tag, "_memr"}, {31'd0, MemRead_EXE}, {31'd0, exp_q.memr});
    check({tag, "_memw"}, {31'd0, MemWrite_EXE}, {31'd0, exp_q.memw});
    check({tag, "_ctrl"}, {26'd0, Ctrl_EXE}, {26'd0, exp_q.ctrl});
    check({tag, "_rd1"}, ReadData1_EXE, exp_q.rd1);
    check({tag, "_rd2"}, ReadData2_EXE, exp_q.rd2);
    check({tag, "_imm"}, Imm_EXE, exp_q.imm);
    check({tag, "_pc4"}, PC4_EXE, exp_q.pc4);
    check({tag, "_rs"}, {27'd0, Rs_EXE}, {27'd0, exp_q.rs});
    check({tag, "_rt"}, {27'd0, Rt_EXE}, {27'd0, exp_q.rt});
    check({tag, "_rd"}, {27'd0, Rd_EXE}, {27'd0, exp_q.rd});
    check({tag, "_cnt"}, BubbleCount, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_q = '{default: '0};
    exp_cnt = 32'd0;
    rst = 1'b1; Flush_EX = 1'b0; Stall_EXT = 1'b0; Valid_ID = 1'b0;
    RegWrite_ID = 1'b0; MemRead_ID = 1'b0; MemWrite_ID = 1'b0; UsesRt_ID = 1'b0;
    Rs_ID = '0; Rt_ID = '0; Rd_ID = '0; Ctrl_ID = '0;
    ReadData1_ID = '0; ReadData2_ID = '0; Imm_ID = '0; PC4_ID = '0;

    //          rst f s v rw mr mw ur  rs  rt  rd  d       pcw bub act
    tbl[0]  = mk(1, 0, 0, 1, 1, 1, 0, 1, 8,  8,  0,  32'd11,   1, 0, A_RST);
    tbl[1]  = mk(1, 0, 0, 1, 1, 1, 0, 1, 8,  8,  0,  32'd12,   1, 0, A_RST);
    tbl[2]  = mk(0, 0, 0, 1, 1, 1, 0, 0, 2,  8,  0,  32'd100,  1, 0, A_LOAD);
    tbl[3]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 8,  9,  10, 32'd200,  0, 1, A_BUB);
    tbl[4]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 8,  9,  10, 32'd200,  1, 0, A_LOAD);
    tbl[5]  = mk(0, 0, 0, 1, 1, 1, 0, 0, 1,  5,  0,  32'd300,  1, 0, A_LOAD);
    tbl[6]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 3,  5,  6,  32'd400,  0, 1, A_BUB);
    tbl[7]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 3,  5,  6,  32'd400,  1, 0, A_LOAD);
    tbl[8]  = mk(0, 0, 0, 1, 1, 1, 0, 0, 1,  5,  0,  32'd500,  1, 0, A_LOAD);
    tbl[9]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 3,  5,  6,  32'd600,  1, 0, A_LOAD);
    tbl[10] = mk(0, 0, 0, 1, 1, 1, 0, 0, 1,  0,  0,  32'd700,  1, 0, A_LOAD);
    tbl[11] = mk(0, 0, 0, 1, 1, 0, 0, 1, 0,  0,  4,  32'd800,  1, 0, A_LOAD);
    tbl[12] = mk(0, 0, 0, 1, 1, 1, 0, 0, 1,  7,  0,  32'd900,  1, 0, A_LOAD);
    tbl[13] = mk(0, 1, 0, 1, 1, 0, 0, 1, 7,  3,  4,  32'd950,  1, 0, A_BUB);
    tbl[14] = mk(0, 0, 0, 1, 1, 0, 1, 1, 7,  3,  4,  32'd1000, 1, 0, A_LOAD);
    tbl[15] = mk(0, 0, 0, 1, 1, 1, 0, 0, 1,  6,  0,  32'd1100, 1, 0, A_LOAD);
    tbl[16] = mk(0, 0, 1, 1, 1, 0, 0, 1, 6,  2,  3,  32'd1200, 0, 0, A_HOLD);
    tbl[17] = mk(0, 0, 1, 1, 0, 0, 1, 1, 6,  2,  3,  32'd1300, 0, 0, A_HOLD);
    tbl[18] = mk(0, 0, 1, 1, 1, 1, 0, 0, 4,  9,  3,  32'd1400, 0, 0, A_HOLD);
    tbl[19] = mk(0, 0, 0, 1, 1, 0, 0, 1, 6,  2,  3,  32'd1500, 0, 1, A_BUB);
    tbl[20] = mk(0, 0, 0, 1, 1, 0, 0, 1, 6,  2,  3,  32'd1500, 1, 0, A_LOAD);
    tbl[21] = mk(0, 0, 0, 0, 1, 1, 1, 1, 1,  3,  0,  32'd1600, 1, 0, A_BUB);
    tbl[22] = mk(0, 0, 0, 1, 1, 1, 0, 0, 1,  3,  0,  32'd1700, 1, 0, A_LOAD);
    tbl[23] = mk(0, 0, 0, 0, 1, 0, 0, 1, 3,  3,  5,  32'd1750, 1, 0, A_BUB);
    tbl[24] = mk(0, 0, 0, 1, 1, 1, 0, 0, 1,  2,  0,  32'd1800, 1, 0, A_LOAD);
    tbl[25] = mk(0, 0, 1, 1, 1, 0, 0, 1, 2,  4,  5,  32'd1900, 0, 0, A_HOLD);
    tbl[26] = mk(1, 0, 1, 1, 1, 0, 0, 1, 2,  4,  5,  32'd1900, 1, 0, A_RST);
    tbl[27] = mk(0, 0, 0, 1, 1, 0, 0, 1, 2,  4,  5,  32'd2000, 1, 0, A_LOAD);

    for (int i = 0; i < 28; i++) run_vec($sformatf("v%0d", i), tbl[i]);

`ifdef HAZ_PERF_CNT_EN
    // Preload the counter just below saturation, then cause two load-use bubbles.
    sat[0] = mk(0, 0, 0, 1, 1, 1, 0, 0, 1, 8, 0, 32'd3000, 1, 0, A_LOAD);
    sat[1] = mk(0, 0, 0, 1, 1, 0, 0, 1, 8, 2, 3, 32'd3100, 0, 1, A_BUB);
    sat[2] = mk(0, 0, 0, 1, 1, 1, 0, 0, 1, 9, 0, 32'd3200, 1, 0, A_LOAD);
    sat[3] = mk(0, 0, 0, 1, 1, 0, 0, 1, 9, 2, 3, 32'd3300, 0, 1, A_BUB);
    sat[4] = mk(0, 0, 0, 1, 1, 0, 0, 1, 9, 2, 3, 32'd3300, 1, 0, A_LOAD);
    @(negedge clk);
    force dut.bubble_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_cnt;
    exp_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 5; i++) run_vec($sformatf("sat%0d", i), sat[i]);
`else
    sat[0] = mk(0, 0, 0, 1, 1, 1, 0, 0, 1, 8, 0, 32'd3000, 1, 0, A_LOAD);
    sat[1] = mk(0, 0, 0, 1, 1, 0, 0, 1, 8, 2, 3, 32'd3100, 0, 1, A_BUB);
    for (int i = 0; i < 2; i++) run_vec($sformatf("off%0d", i), sat[i]);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
